// File: rtl/recurse_mux.sv
// recurse_mux: 2^S-to-1 multiplexer of T-bit words built as a recursive
// binary tree of 2:1 stages. The tree is purely combinational; only the
// top-level output is registered, giving one cycle of latency and a
// synchronous active-high clear.

// Combinational tree node. Recurses on the select width until a single
// 2:1 stage remains.
module recurse_mux_tree #(
    parameter int S = 2,
    parameter int T = 1
) (
    output logic [T-1:0]         m,
    input  logic [(2**S)*T-1:0]  d,
    input  logic [S-1:0]         s
);

    // Bit width of one half of the packed input vector.
    localparam int HALF_W = (2**(S-1)) * T;

    generate
        if (S == 1) begin : g_leaf
            // Leaf: a single 2:1 stage between word 1 and word 0.
            assign m = s[0] ? d[2*T-1:T] : d[T-1:0];
        end else begin : g_node
            logic [T-1:0] lo_s;
            logic [T-1:0] hi_s;

            // Lower sub-tree handles words 0 .. 2^(S-1)-1.
            recurse_mux_tree #(
                .S (S - 1),
                .T (T)
            ) u_lo (
                .m (lo_s),
                .d (d[HALF_W-1:0]),
                .s (s[S-2:0])
            );

            // Upper sub-tree handles the remaining words.
            recurse_mux_tree #(
                .S (S - 1),
                .T (T)
            ) u_hi (
                .m (hi_s),
                .d (d[2*HALF_W-1:HALF_W]),
                .s (s[S-2:0])
            );

            // Final stage: the select MSB chooses between the two halves.
            assign m = s[S-1] ? hi_s : lo_s;
        end
    endgenerate

endmodule

// Top level: combinational tree followed by the single output register.
module recurse_mux #(
    parameter int S = 2,
    parameter int T = 1
) (
    output logic [T-1:0]         z,
    input  logic [(2**S)*T-1:0]  d,
    input  logic [S-1:0]         s,
    input  logic                 clk,
    input  logic                 rst
);

    logic [T-1:0] sel_s;

    recurse_mux_tree #(
        .S (S),
        .T (T)
    ) u_tree (
        .m (sel_s),
        .d (d),
        .s (s)
    );

    // Output register: clear on reset, otherwise capture the selected word.
    always_ff @(posedge clk) begin
        if (rst) begin
            z <= {T{1'b0}};
        end else begin
            z <= sel_s;
        end
    end

endmodule

// File: tb/tb_recurse_mux.sv
// tb_recurse_mux: scoreboard bench for recurse_mux across several
// (S, T) configurations sharing one clock and one reset.
module tb_recurse_mux;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // S=2, T=1
    logic [3:0]  d_a;
    logic [1:0]  s_a;
    logic        z_a;
    // S=2, T=4
    logic [15:0] d_w;
    logic [1:0]  s_w;
    logic [3:0]  z_w;
    // S=1, T=8
    logic [15:0] d_b;
    logic        s_b;
    logic [7:0]  z_b;
    // S=4, T=1
    logic [15:0] d_d;
    logic [3:0]  s_d;
    logic        z_d;

    int checks = 0;
    int errors = 0;

    logic       q_a[$];
    logic [3:0] q_w[$];
    logic [7:0] q_b[$];
    logic       q_d[$];

    recurse_mux #(.S(2), .T(1)) u_a (.z(z_a), .d(d_a), .s(s_a), .clk(clk), .rst(rst));
    recurse_mux #(.S(2), .T(4)) u_w (.z(z_w), .d(d_w), .s(s_w), .clk(clk), .rst(rst));
    recurse_mux #(.S(1), .T(8)) u_b (.z(z_b), .d(d_b), .s(s_b), .clk(clk), .rst(rst));
    recurse_mux #(.S(4), .T(1)) u_d (.z(z_d), .d(d_d), .s(s_d), .clk(clk), .rst(rst));

    task automatic test_reset();
        logic exp;
        logic [3:0] exp_w;
        d_a = 4'b1111;
        s_a = 2'd0;
        d_w = 16'hDCBA;
        s_w = 2'd3;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            q_a.push_back(1'b0);
            q_w.push_back(4'h0);
            @(posedge clk);
            #1;
            exp = q_a.pop_front();
            exp_w = q_w.pop_front();
            checks++;
            if (z_a !== exp) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: z=%b expected %b", i, z_a, exp);
            end
            checks++;
            if (z_w !== exp_w) begin
                errors++;
                $display("FAIL reset_wide cycle %0d: z=%h expected %h", i, z_w, exp_w);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        q_a.push_back(d_a[s_a]);
        @(posedge clk);
        #1;
        exp = q_a.pop_front();
        checks++;
        if (z_a !== exp) begin
            errors++;
            $display("FAIL reset_release: z=%b expected %b", z_a, exp);
        end
    endtask

    task automatic test_base();
        logic exp;
        d_a = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_a = i[1:0];
            q_a.push_back(d_a[s_a]);
            @(posedge clk);
            #1;
            exp = q_a.pop_front();
            checks++;
            if (z_a !== exp) begin
                errors++;
                $display("FAIL base_select s=%0d: z=%b expected %b", i, z_a, exp);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic exp;
        d_a = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_a = i[1:0];
            rst = (i == 1) ? 1'b1 : 1'b0;
            if (rst) q_a.push_back(1'b0);
            else     q_a.push_back(d_a[s_a]);
            @(posedge clk);
            #1;
            exp = q_a.pop_front();
            checks++;
            if (z_a !== exp) begin
                errors++;
                $display("FAIL midstream_reset step %0d: z=%b expected %b", i, z_a, exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wide();
        logic [3:0] exp;
        logic [3:0] want [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        d_w = {4'hD, 4'hC, 4'hB, 4'hA};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_w = i[1:0];
            q_w.push_back(want[i]);
            @(posedge clk);
            #1;
            exp = q_w.pop_front();
            checks++;
            if (z_w !== exp) begin
                errors++;
                $display("FAIL wide_select s=%0d: z=%h expected %h", i, z_w, exp);
            end
        end
    endtask

    task automatic test_base_case();
        logic [7:0] exp;
        d_b = {8'h5A, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_b = i[0];
            q_b.push_back((i == 0) ? 8'hA5 : 8'h5A);
            @(posedge clk);
            #1;
            exp = q_b.pop_front();
            checks++;
            if (z_b !== exp) begin
                errors++;
                $display("FAIL base_case s=%0d: z=%h expected %h", i, z_b, exp);
            end
        end
    endtask

    task automatic test_deep();
        logic exp;
        d_d = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_d = i[3:0];
            q_d.push_back((i == 0 || i == 15) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            exp = q_d.pop_front();
            checks++;
            if (z_d !== exp) begin
                errors++;
                $display("FAIL deep_tree s=%0d: z=%b expected %b", i, z_d, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_w;
        logic       exp_d;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d_w = 16'($urandom);
            s_w = 2'($urandom_range(0, 3));
            d_d = 16'($urandom);
            s_d = 4'($urandom_range(0, 15));
            q_w.push_back(d_w[s_w*4 +: 4]);
            q_d.push_back(d_d[s_d]);
            @(posedge clk);
            #1;
            exp_w = q_w.pop_front();
            exp_d = q_d.pop_front();
            checks++;
            if (z_w !== exp_w) begin
                errors++;
                $display("FAIL b2b_wide step %0d: z=%h expected %h", i, z_w, exp_w);
            end
            checks++;
            if (z_d !== exp_d) begin
                errors++;
                $display("FAIL b2b_deep step %0d: z=%b expected %b", i, z_d, exp_d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        d_a = 4'h0;  s_a = 2'd0;
        d_w = 16'h0; s_w = 2'd0;
        d_b = 16'h0; s_b = 1'b0;
        d_d = 16'h0; s_d = 4'd0;
        test_reset();
        test_base();
        test_midstream_reset();
        test_wide();
        test_base_case();
        test_deep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/recurse_mux.md
# recurse_mux

Parameterised 2^S-to-1 multiplexer of T-bit words, built as a recursive binary tree of 2:1 stages with a single registered output. It is the generic selection primitive of the routing library. Callers that need wide, arbitrary-depth selection with one cycle of latency and a synchronous clear use this block.

## Interface

Parameters:
- S, default 2: select width; the block has 2^S inputs. Legal range is S ≥ 1.
- T, default 1: width of each input word and of the output.

Ports:
- clk, input, 1 bit: single clock; all state updates on the rising edge.
- rst, input, 1 bit: synchronous, active-high reset.
- z, output, T bits: registered selected word.
- d, input, (2^S)·T bits: packed inputs. Word i occupies d[i·T+T-1 : i·T]; word 0 is in the LSBs.
- s, input, S bits: binary select index. s[S-1] is the MSB.

Declaration order is z, d, s, clk, rst, so positional (z, d, s) connections of the first three ports keep their meaning.

## Operation

- Combinational select m = word number s of d, treating s as an unsigned integer 0..2^S-1.
- Recursive structure:
  - S = 1: a single 2:1 mux; m = s[0] ? word1 : word0.
  - S > 1: two recurse_mux-style sub-trees of depth S-1. The lower one takes words 0..2^(S-1)-1 and the upper one takes the remaining words, both selected by s[S-2:0].
  - A final 2:1 stage picks the upper result when s[S-1] = 1, otherwise the lower result.
  - The internal tree levels are purely combinational. Only the top-level output is registered.
- Register: on each rising clk edge, z ← 0 if rst = 1, else z ← m.
- Every T bit lane is independent; there is no mixing across lanes.
- All 2^S select values are valid; no out-of-range case exists.
- There is no enable or handshake. The output follows the selection every cycle.
- X or Z on d or s propagates per standard mux semantics. No special handling.

## Timing

- Latency is 1 cycle. z after edge k equals word s(k) of d(k), where d and s are sampled just before edge k.
- Reset:
  - z = 0 (all T bits) on the first edge with rst = 1, and it stays 0 while rst is held.
  - On the first edge after rst deasserts, z loads the current selection.
- Reset mid-operation clears z at the next edge and discards any in-flight selection.
- Before the first clock edge, z is undefined.
- When d and s change simultaneously, the next edge captures the new d word at the new index.
- Throughput is one new selection per cycle.
- The combinational path is S mux levels deep from s or d to the z register input. Callers with large S budget that path in timing.

## Test plan

- Base selection (S=2, T=1, d = 4'b0101, so d[0]=1, d[1]=0, d[2]=1, d[3]=0): apply s = 0, 1, 2, 3 on successive cycles. After each edge z must read 1, 0, 1, 0.
- Reset (S=2, T=1, d = 4'b1111, s = 0): hold rst = 1 for 2 edges, then z = 0. Release rst; after the next edge z = 1.
- Mid-stream reset: while cycling s with d = 4'b0101, assert rst for one edge; z = 0 that cycle. Next edge, z = d[s].
- Wide words (S=2, T=4, d = {4'hD, 4'hC, 4'hB, 4'hA}): s = 0..3 gives z = A, B, C, D one cycle later. There must be no lane cross-talk.
- Base case (S=1, T=8, d = {8'h5A, 8'hA5}): s = 0 gives z = A5 and s = 1 gives z = 5A.
- Deep tree (S=4, T=1, d = 16'h8001): s = 0 and s = 15 give z = 1; every other s gives z = 0.
